// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on
// operand magnitudes; the sign fixup is folded into the final step so every
// operation, including the divide special cases, has the same latency.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MDStart,
    input  logic             MDFlush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] MDResult,
    output logic             MDDone,
    output logic             MDStall
);

    localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Operation flags latched at acceptance
    logic               is_div_q, is_div_d;
    logic               hi_sel_q, hi_sel_d;   // mul: high half; div: remainder
    logic               neg_q, neg_d;         // negate the selected result

    // Iteration registers: mul {hi,lo} = partial product / multiplier,
    // div hi = partial remainder, lo = dividend shifting into quotient
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Operand decode
    logic               a_signed, b_signed;
    logic               sign_a, sign_b;
    logic signed [WIDTH-1:0] src_a_s, src_b_s;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               dec_neg, dec_hi_sel;

    // Step datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic is_neg);
        return is_neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                           input logic is_neg);
        return is_neg ? -v : v;
    endfunction

    // Decode operand signedness and take magnitudes for the unsigned core
    always_comb begin
        src_a_s    = SrcA;
        src_b_s    = SrcB;
        a_signed   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
        b_signed   = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
        sign_a     = a_signed && (src_a_s < 0);
        sign_b     = b_signed && (src_b_s < 0);
        mag_a      = apply_sign(SrcA, sign_a);
        mag_b      = apply_sign(SrcB, sign_b);
        dec_hi_sel = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
        // Remainder follows the dividend; a zero divisor keeps the
        // all-ones quotient unsigned-looking regardless of sign
        if (funct3[2]) begin
            dec_neg = funct3[1] ? sign_a : ((sign_a ^ sign_b) && (SrcB != '0));
        end else begin
            dec_neg = sign_a ^ sign_b;
        end
    end

    // One iteration step plus the sign fixup of its outcome
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod_fix = apply_sign_wide({step_hi, step_lo}, neg_q);
        quo_fix  = apply_sign(step_lo, neg_q);
        rem_fix  = apply_sign(step_hi, neg_q);
        if (is_div_q) begin
            final_res = hi_sel_q ? rem_fix : quo_fix;
        end else begin
            final_res = hi_sel_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
        end
    end

    // FSM next state and register updates; flush dominates everything
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        is_div_d = is_div_q;
        hi_sel_d = hi_sel_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (MDFlush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MDStart) begin
                        state_d  = BUSY;
                        cnt_d    = '0;
                        is_div_d = funct3[2];
                        hi_sel_d = dec_hi_sel;
                        neg_d    = dec_neg;
                        hi_d     = '0;
                        if (funct3[2]) begin
                            lo_d   = mag_a;
                            opnd_d = mag_b;
                        end else begin
                            lo_d   = mag_b;
                            opnd_d = mag_a;
                        end
                    end
                end
                BUSY: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        result_d = final_res;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state and the visible result, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Datapath registers; always reloaded before use, so no reset
    always_ff @(posedge clk) begin
        is_div_q <= is_div_d;
        hi_sel_q <= hi_sel_d;
        neg_q    <= neg_d;
        opnd_q   <= opnd_d;
        hi_q     <= hi_d;
        lo_q     <= lo_d;
    end

    assign MDResult = result_q;
    assign MDDone   = (state_q == DONE);
    assign MDStall  = MDStart & ~MDFlush & (state_q != DONE);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed RV32M vectors plus randomized
// operations compared against an arithmetic reference model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MDStart;
    logic        MDFlush;
    logic [2:0]  funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] MDResult;
    logic        MDDone;
    logic        MDStall;

    int checks = 0;
    int errors = 0;

    md_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .MDStart  (MDStart),
        .MDFlush  (MDFlush),
        .funct3   (funct3),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .MDResult (MDResult),
        .MDDone   (MDDone),
        .MDStall  (MDStall)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Present an op from IDLE and follow it to MDDone (or a 40-cycle bound).
    // Returns in the DONE cycle with MDStart still high.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit mutate, output int done_cyc, output bit stall_ok);
        MDStart  = 1'b1;
        MDFlush  = 1'b0;
        funct3   = f3;
        SrcA     = a;
        SrcB     = b;
        done_cyc = -1;
        stall_ok = 1'b1;
        #1;
        if (MDStall !== 1'b1) stall_ok = 1'b0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (mutate && c == 10) begin
                SrcA   = $urandom;
                SrcB   = $urandom;
                funct3 = 3'($urandom);
                #1;
            end
            if (MDDone === 1'b1) begin
                done_cyc = c;
                if (MDStall !== 1'b0) stall_ok = 1'b0;
            end else if (MDStall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
    endtask

    task automatic finish_op();
        MDStart = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int          dc;
        bit          sok;
        bit          seen;
        logic [31:0] got;
        reset = 1'b1; MDStart = 1'b0; MDFlush = 1'b0; funct3 = 3'd0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (MDResult !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 00000000", MDResult); end
        checks++;
        if (MDDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", MDDone); end
        checks++;
        if (MDStall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", MDStall); end
        reset = 1'b0;
        @(posedge clk); #1;
        // leave a nonzero result behind so the reset clear is visible
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, dc, sok);
        got = MDResult;
        checks++;
        if (got !== 32'hFFFF_FFEB) begin errors++; $display("FAIL pre_reset_mul: got %h want FFFFFFEB", got); end
        finish_op();
        // start an op and hit reset in BUSY cycle 10
        MDStart = 1'b1; funct3 = 3'd3; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        checks++;
        if (MDResult !== 32'd0 || MDDone !== 1'b0) begin
            errors++; $display("FAIL midbusy_reset: result %h done %b want 00000000 0", MDResult, MDDone);
        end
        MDStart = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (MDDone === 1'b1) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_done: got done pulse %b want 0", seen); end
        checks++;
        if (MDResult !== 32'd0) begin errors++; $display("FAIL reset_result_held: got %h want 00000000", MDResult); end
        run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, dc, sok);
        checks++;
        if (dc !== 33 || !sok) begin errors++; $display("FAIL post_reset_latency: got %0d stall_ok %b want 33 1", dc, sok); end
        checks++;
        if (MDResult !== ref_md(3'd3, 32'hDEAD_BEEF, 32'h1234_5678)) begin
            errors++; $display("FAIL post_reset_result: got %h want %h", MDResult, ref_md(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
        end
        finish_op();
    endtask

    task automatic test_mul();
        logic [2:0]  dir_f3 [3] = '{3'd0, 3'd1, 3'd3};
        logic [31:0] dir_a  [3] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] dir_b  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] dir_r  [3] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'hFFFF_FFFE};
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        logic [2:0]  f3;
        int          dc;
        bit          sok;
        for (int i = 0; i < 3; i++) begin
            run_op(dir_f3[i], dir_a[i], dir_b[i], 1'b0, dc, sok);
            checks++;
            if (MDResult !== dir_r[i]) begin errors++; $display("FAIL mul_dir%0d: got %h want %h", i, MDResult, dir_r[i]); end
            checks++;
            if (dc !== 33 || !sok) begin errors++; $display("FAIL mul_dir%0d_timing: got %0d stall_ok %b want 33 1", i, dc, sok); end
            finish_op();
        end
        checks++;
        if (MDResult !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_result_hold: got %h want FFFFFFFE", MDResult); end
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(0, 3));
            a  = (i == 0) ? 32'h8000_0000 : $urandom;
            b  = (i == 0 || i == 1) ? 32'h8000_0000 : $urandom;
            want = ref_md(f3, a, b);
            run_op(f3, a, b, 1'b0, dc, sok);
            checks++;
            if (MDResult !== want) begin
                errors++; $display("FAIL mul_rand f3=%0d a=%h b=%h: got %h want %h", f3, a, b, MDResult, want);
            end
            checks++;
            if (dc !== 33 || !sok) begin errors++; $display("FAIL mul_rand_timing: got %0d stall_ok %b want 33 1", dc, sok); end
            finish_op();
        end
    endtask

    task automatic test_div();
        logic [2:0]  dir_f3 [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] dir_a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] dir_b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] dir_r  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        logic [2:0]  f3;
        int          dc;
        bit          sok;
        for (int i = 0; i < 4; i++) begin
            run_op(dir_f3[i], dir_a[i], dir_b[i], 1'b0, dc, sok);
            checks++;
            if (MDResult !== dir_r[i]) begin errors++; $display("FAIL div_dir%0d: got %h want %h", i, MDResult, dir_r[i]); end
            checks++;
            if (dc !== 33 || !sok) begin errors++; $display("FAIL div_dir%0d_timing: got %0d stall_ok %b want 33 1", i, dc, sok); end
            finish_op();
        end
        for (int i = 0; i < 20; i++) begin
            f3 = 3'($urandom_range(4, 7));
            a  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            case (i % 4)
                0:       b = $urandom_range(1, 300);
                1:       b = 32'd0;
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            want = ref_md(f3, a, b);
            run_op(f3, a, b, 1'b0, dc, sok);
            checks++;
            if (MDResult !== want) begin
                errors++; $display("FAIL div_rand f3=%0d a=%h b=%h: got %h want %h", f3, a, b, MDResult, want);
            end
            checks++;
            if (dc !== 33 || !sok) begin errors++; $display("FAIL div_rand_timing: got %0d stall_ok %b want 33 1", dc, sok); end
            finish_op();
        end
    endtask

    task automatic test_special();
        logic [2:0]  sp_f3 [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] sp_a  [4] = '{32'h0000_1234, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] sp_b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] sp_r  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int dc;
        bit sok;
        for (int i = 0; i < 4; i++) begin
            run_op(sp_f3[i], sp_a[i], sp_b[i], 1'b0, dc, sok);
            checks++;
            if (MDResult !== sp_r[i]) begin errors++; $display("FAIL special%0d: got %h want %h", i, MDResult, sp_r[i]); end
            checks++;
            if (dc !== 33 || !sok) begin errors++; $display("FAIL special%0d_timing: got %0d stall_ok %b want 33 1", i, dc, sok); end
            finish_op();
        end
    endtask

    task automatic test_flush();
        logic [31:0] prior;
        logic [31:0] a;
        logic [31:0] b;
        int          dc;
        bit          sok;
        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, dc, sok);
        prior = ref_md(3'd3, 32'hFFFF_FFFF, 32'h0000_0010);
        checks++;
        if (MDResult !== prior) begin errors++; $display("FAIL flush_prior: got %h want %h", MDResult, prior); end
        finish_op();
        MDStart = 1'b1; funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd7;
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        MDFlush = 1'b1;
        #1;
        checks++;
        if (MDStall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", MDStall); end
        @(posedge clk); #1;
        MDFlush = 1'b0;
        checks++;
        if (MDDone !== 1'b0 || MDResult !== prior) begin
            errors++; $display("FAIL flush_idle: done %b result %h want 0 %h", MDDone, MDResult, prior);
        end
        a = $urandom; b = $urandom_range(1, 1000);
        run_op(3'd6, a, b, 1'b0, dc, sok);
        checks++;
        if (dc !== 33 || !sok) begin errors++; $display("FAIL after_flush_timing: got %0d stall_ok %b want 33 1", dc, sok); end
        checks++;
        if (MDResult !== ref_md(3'd6, a, b)) begin
            errors++; $display("FAIL after_flush_result: got %h want %h", MDResult, ref_md(3'd6, a, b));
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a2;
        logic [31:0] b2;
        int          dc;
        bit          sok;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 50000);
        run_op(3'd1, a1, b1, 1'b1, dc, sok);
        checks++;
        if (MDResult !== ref_md(3'd1, a1, b1)) begin
            errors++; $display("FAIL b2b_first: got %h want %h", MDResult, ref_md(3'd1, a1, b1));
        end
        checks++;
        if (dc !== 33 || !sok) begin errors++; $display("FAIL b2b_first_timing: got %0d stall_ok %b want 33 1", dc, sok); end
        funct3 = 3'd4; SrcA = a2; SrcB = b2;
        @(posedge clk); #1;
        checks++;
        if (MDDone !== 1'b0 || MDStall !== 1'b1) begin
            errors++; $display("FAIL b2b_idle: done %b stall %b want 0 1", MDDone, MDStall);
        end
        run_op(3'd4, a2, b2, 1'b0, dc, sok);
        checks++;
        if (dc !== 33 || !sok) begin errors++; $display("FAIL b2b_second_timing: got %0d stall_ok %b want 33 1", dc, sok); end
        checks++;
        if (MDResult !== ref_md(3'd4, a2, b2)) begin
            errors++; $display("FAIL b2b_second: got %h want %h", MDResult, ref_md(3'd4, a2, b2));
        end
        finish_op();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
